// File: rtl/hls_snn_izikevich_hls_deadlock_reporter_pkg.sv
// Shared definitions for the deadlock reporter: FSM state encoding and default
// geometry of the monitored design.
package hls_snn_izikevich_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_REPORT = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int DEF_THRESHOLD = 16;
  localparam int DEF_AXIS_W    = 6;
  localparam int DEF_INST_W    = 4;
  localparam int DEF_TS_W      = 32;
  localparam int DEF_EVT_W     = 8;

  // Bits needed for a window counter that must be able to hold THRESHOLD itself.
  function automatic int win_width(input int thr);
    return (thr < 1) ? 1 : $clog2(thr + 1);
  endfunction

endpackage

// File: rtl/hls_snn_izikevich_hls_deadlock_reporter_if.sv
// Monitor-facing inputs and host-facing snapshot handshake of the deadlock reporter.
// The master side is the surrounding design / host, the slave side is the reporter.
interface hls_snn_izikevich_hls_deadlock_reporter_if
  import hls_snn_izikevich_deadlock_pkg::*;
#(
  parameter int AXIS_W = DEF_AXIS_W,
  parameter int INST_W = DEF_INST_W,
  parameter int TS_W   = DEF_TS_W,
  parameter int EVT_W  = DEF_EVT_W
) ();

  logic              block;
  logic [AXIS_W-1:0] axis_block_sigs;
  logic [INST_W-1:0] inst_idle_sigs;
  logic              flag_clear;
  logic              report_valid;
  logic              report_ready;
  logic [AXIS_W-1:0] report_axis;
  logic [INST_W-1:0] report_idle;
  logic [TS_W-1:0]   report_ts;
  logic              deadlock_flag;
  logic [EVT_W-1:0]  event_count;

  modport master (
    output block, axis_block_sigs, inst_idle_sigs, flag_clear, report_ready,
    input  report_valid, report_axis, report_idle, report_ts, deadlock_flag, event_count
  );

  modport slave (
    input  block, axis_block_sigs, inst_idle_sigs, flag_clear, report_ready,
    output report_valid, report_axis, report_idle, report_ts, deadlock_flag, event_count
  );

endinterface

// File: rtl/hls_snn_izikevich_hls_deadlock_reporter_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for the cycle
// timestamp and for the report event count.
module hls_snn_izikevich_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hls_snn_izikevich_hls_deadlock_reporter.sv
// Qualifies the deadlock monitor's block verdict over a persistence window and
// hands one diagnostic snapshot per deadlock episode to the host.
module hls_snn_izikevich_hls_deadlock_reporter
  import hls_snn_izikevich_deadlock_pkg::*;
#(
  parameter int THRESHOLD = DEF_THRESHOLD,
  parameter int AXIS_W    = DEF_AXIS_W,
  parameter int INST_W    = DEF_INST_W,
  parameter int TS_W      = DEF_TS_W,
  parameter int EVT_W     = DEF_EVT_W
) (
  input  logic clock,
  input  logic reset,
  hls_snn_izikevich_hls_deadlock_reporter_if.slave bus
);

  localparam int WIN_W = win_width(THRESHOLD);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(THRESHOLD);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIN_W-1:0]  r_win_cnt;
  logic [WIN_W-1:0]  w_win_cnt_nxt;
  logic [WIN_W-1:0]  w_win_inc;
  logic [AXIS_W-1:0] r_acc;
  logic [AXIS_W-1:0] w_acc_nxt;
  logic              w_capture;

  logic [AXIS_W-1:0] r_axis;
  logic [INST_W-1:0] r_idle;
  logic [TS_W-1:0]   r_ts;
  logic              r_flag;
  logic [TS_W-1:0]   w_cycle;
  logic [EVT_W-1:0]  w_evt;

  assign w_win_inc = r_win_cnt + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_win_cnt_nxt = r_win_cnt;
    w_acc_nxt     = r_acc;
    w_capture     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.block) begin
          if (THRESHOLD == 1) begin
            w_capture     = 1'b1;
            w_win_cnt_nxt = '0;
            w_acc_nxt     = '0;
            w_state_nxt   = ST_REPORT;
          end else begin
            w_win_cnt_nxt = WIN_ONE;
            w_acc_nxt     = bus.axis_block_sigs;
            w_state_nxt   = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        if (!bus.block) begin
          w_win_cnt_nxt = '0;
          w_acc_nxt     = '0;
          w_state_nxt   = ST_IDLE;
        end else if (w_win_inc == WIN_LAST) begin
          // Window complete: the snapshot registers take acc|sigs this cycle,
          // so the accumulator is free to restart from zero.
          w_capture     = 1'b1;
          w_win_cnt_nxt = '0;
          w_acc_nxt     = '0;
          w_state_nxt   = ST_REPORT;
        end else begin
          w_win_cnt_nxt = w_win_inc;
          w_acc_nxt     = r_acc | bus.axis_block_sigs;
        end
      end
      ST_REPORT: begin
        if (bus.report_ready) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!bus.block) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_win_cnt <= '0;
      r_acc     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_win_cnt <= w_win_cnt_nxt;
      r_acc     <= w_acc_nxt;
    end
  end

  // Snapshot stage: frozen from capture until the next capture, so it stays
  // stable for the whole time the report is pending.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_axis <= '0;
      r_idle <= '0;
      r_ts   <= '0;
    end else if (w_capture) begin
      r_axis <= r_acc | bus.axis_block_sigs;
      r_idle <= bus.inst_idle_sigs;
      r_ts   <= w_cycle;
    end
  end

  // Set has priority so a clear racing a new report never hides it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_flag <= 1'b0;
    end else if (w_capture) begin
      r_flag <= 1'b1;
    end else if (bus.flag_clear) begin
      r_flag <= 1'b0;
    end
  end

  hls_snn_izikevich_sat_counter #(.WIDTH(TS_W)) u_cycle_cnt (
    .clk     (clock),
    .rst     (reset),
    .i_en    (1'b1),
    .o_count (w_cycle)
  );

  hls_snn_izikevich_sat_counter #(.WIDTH(EVT_W)) u_event_cnt (
    .clk     (clock),
    .rst     (reset),
    .i_en    (w_capture),
    .o_count (w_evt)
  );

  assign bus.report_valid  = (r_state == ST_REPORT);
  assign bus.report_axis   = r_axis;
  assign bus.report_idle   = r_idle;
  assign bus.report_ts     = r_ts;
  assign bus.deadlock_flag = r_flag;
  assign bus.event_count   = w_evt;

endmodule

// File: tb/tb_hls_snn_izikevich_hls_deadlock_reporter.sv
// Directed bench for the deadlock reporter: a THRESHOLD=16 instance for the
// window/handshake scenarios and a THRESHOLD=1, 4-bit-timestamp instance for saturation.
module tb_hls_snn_izikevich_hls_deadlock_reporter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hls_snn_izikevich_hls_deadlock_reporter_if #(.AXIS_W(6), .INST_W(4), .TS_W(32), .EVT_W(8)) bus1 ();
  hls_snn_izikevich_hls_deadlock_reporter_if #(.AXIS_W(6), .INST_W(4), .TS_W(4),  .EVT_W(8)) bus2 ();

  hls_snn_izikevich_hls_deadlock_reporter #(
    .THRESHOLD(16), .AXIS_W(6), .INST_W(4), .TS_W(32), .EVT_W(8)
  ) dut1 (
    .clock (clk),
    .reset (rst),
    .bus   (bus1)
  );

  hls_snn_izikevich_hls_deadlock_reporter #(
    .THRESHOLD(1), .AXIS_W(6), .INST_W(4), .TS_W(4), .EVT_W(8)
  ) dut2 (
    .clock (clk),
    .reset (rst),
    .bus   (bus2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus1.block = 1'b0; bus1.axis_block_sigs = '0; bus1.inst_idle_sigs = '0;
    bus1.flag_clear = 1'b0; bus1.report_ready = 1'b0;
    bus2.block = 1'b0; bus2.axis_block_sigs = '0; bus2.inst_idle_sigs = '0;
    bus2.flag_clear = 1'b0; bus2.report_ready = 1'b0;
  endtask

  // Leaves the bench in cycle 0: reset just released, cycle counter reads 0.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus1.block = 1'b1; bus1.axis_block_sigs = 6'h3F; bus1.inst_idle_sigs = 4'hA;
    bus1.report_ready = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus1.report_valid, bus1.deadlock_flag, bus1.event_count, bus1.report_axis,
           bus1.report_idle, bus1.report_ts} !== '0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got v=%0b f=%0b e=%0d ax=%0h id=%0h ts=%0d required all 0",
                 i, bus1.report_valid, bus1.deadlock_flag, bus1.event_count,
                 bus1.report_axis, bus1.report_idle, bus1.report_ts);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus1.report_valid !== 1'b0) begin
        errors++; $display("FAIL reset_early_valid cyc%0d: got %0b required 0", i, bus1.report_valid);
      end
      tick();
    end
    checks++;
    if (bus1.report_valid !== 1'b1) begin
      errors++; $display("FAIL reset_window_valid: got %0b required 1", bus1.report_valid);
    end
    checks++;
    if (bus1.report_ts !== 32'd15) begin
      errors++; $display("FAIL reset_window_ts: got %0d required 15", bus1.report_ts);
    end
    checks++;
    if (bus1.report_axis !== 6'h3F || bus1.report_idle !== 4'hA) begin
      errors++; $display("FAIL reset_window_data: got ax=%0h id=%0h required 3f a",
                         bus1.report_axis, bus1.report_idle);
    end
    bus1.block = 1'b0;
    tick();
    checks++;
    if (bus1.report_valid !== 1'b0) begin
      errors++; $display("FAIL reset_window_accept: got %0b required 0", bus1.report_valid);
    end
  endtask

  task automatic test_reset_midreport();
    do_reset();
    bus1.block = 1'b1;
    repeat (16) tick();
    checks++;
    if (bus1.report_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_pending: got %0b required 1", bus1.report_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus1.block = 1'b0;
    checks++;
    if ({bus1.report_valid, bus1.deadlock_flag, bus1.event_count} !== '0) begin
      errors++; $display("FAIL midrst_drop: got v=%0b f=%0b e=%0d required 0 0 0",
                         bus1.report_valid, bus1.deadlock_flag, bus1.event_count);
    end
    tick();
    checks++;
    if (bus1.report_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_after: got %0b required 0", bus1.report_valid);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    bus1.report_ready = 1'b1; bus1.axis_block_sigs = 6'h01; bus1.inst_idle_sigs = 4'h5;
    repeat (10) tick();
    bus1.block = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus1.report_valid !== 1'b0) begin
        errors++; $display("FAIL nominal_early_valid cyc%0d: got %0b required 0", 10 + i, bus1.report_valid);
      end
      tick();
    end
    checks++;
    if (bus1.report_valid !== 1'b1) begin
      errors++; $display("FAIL nominal_valid_t26: got %0b required 1", bus1.report_valid);
    end
    checks++;
    if (bus1.report_ts !== 32'd25) begin
      errors++; $display("FAIL nominal_ts: got %0d required 25", bus1.report_ts);
    end
    checks++;
    if (bus1.event_count !== 8'd1 || bus1.deadlock_flag !== 1'b1) begin
      errors++; $display("FAIL nominal_evt_flag: got e=%0d f=%0b required 1 1",
                         bus1.event_count, bus1.deadlock_flag);
    end
    checks++;
    if (bus1.report_axis !== 6'h01 || bus1.report_idle !== 4'h5) begin
      errors++; $display("FAIL nominal_data: got ax=%0h id=%0h required 1 5",
                         bus1.report_axis, bus1.report_idle);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus1.report_valid !== 1'b0 || bus1.deadlock_flag !== 1'b1) begin
        errors++; $display("FAIL nominal_single_report[%0d]: got v=%0b f=%0b required 0 1",
                           i, bus1.report_valid, bus1.deadlock_flag);
      end
    end
    bus1.flag_clear = 1'b1;
    tick();
    bus1.flag_clear = 1'b0;
    checks++;
    if (bus1.deadlock_flag !== 1'b0 || bus1.event_count !== 8'd1) begin
      errors++; $display("FAIL nominal_flag_clear: got f=%0b e=%0d required 0 1",
                         bus1.deadlock_flag, bus1.event_count);
    end
    bus1.block = 1'b0;
    tick();
  endtask

  task automatic test_glitch();
    do_reset();
    bus1.report_ready = 1'b1;
    bus1.block = 1'b1; bus1.axis_block_sigs = 6'b100000;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (bus1.report_valid !== 1'b0) begin
        errors++; $display("FAIL glitch_burst1[%0d]: got %0b required 0", i, bus1.report_valid);
      end
    end
    bus1.block = 1'b0; bus1.axis_block_sigs = '0;
    tick();
    bus1.block = 1'b1; bus1.axis_block_sigs = 6'b000010;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (bus1.report_valid !== 1'b0) begin
        errors++; $display("FAIL glitch_burst2[%0d]: got %0b required 0", i, bus1.report_valid);
      end
    end
    tick();
    checks++;
    if (bus1.report_valid !== 1'b1) begin
      errors++; $display("FAIL glitch_late_report: got %0b required 1", bus1.report_valid);
    end
    checks++;
    if (bus1.report_axis !== 6'b000010) begin
      errors++; $display("FAIL glitch_acc_cleared: got %b required 000010", bus1.report_axis);
    end
    bus1.block = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus1.block = 1'b1; bus1.axis_block_sigs = 6'b001100; bus1.inst_idle_sigs = 4'h3;
    repeat (16) tick();
    checks++;
    if (bus1.report_valid !== 1'b1) begin
      errors++; $display("FAIL bp_valid: got %0b required 1", bus1.report_valid);
    end
    for (int i = 0; i < 20; i++) begin
      bus1.block = i[0];
      bus1.axis_block_sigs = 6'(i * 7);
      bus1.inst_idle_sigs = ~4'(i);
      tick();
      checks++;
      if (bus1.report_valid !== 1'b1 || bus1.report_axis !== 6'b001100 ||
          bus1.report_idle !== 4'h3 || bus1.report_ts !== 32'd15) begin
        errors++; $display("FAIL bp_stable[%0d]: got v=%0b ax=%0h id=%0h ts=%0d required 1 c 3 15",
                           i, bus1.report_valid, bus1.report_axis, bus1.report_idle, bus1.report_ts);
      end
    end
    checks++;
    if (bus1.event_count !== 8'd1) begin
      errors++; $display("FAIL bp_evt_pending: got %0d required 1", bus1.event_count);
    end
    bus1.block = 1'b1; bus1.report_ready = 1'b1;
    tick();
    checks++;
    if (bus1.report_valid !== 1'b0) begin
      errors++; $display("FAIL bp_accept: got %0b required 0", bus1.report_valid);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus1.report_valid !== 1'b0) begin
        errors++; $display("FAIL bp_no_rereport[%0d]: got %0b required 0", i, bus1.report_valid);
      end
    end
    bus1.block = 1'b0;
    tick();
    bus1.block = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (bus1.report_valid !== 1'b0) begin
        errors++; $display("FAIL bp_rearm_early[%0d]: got %0b required 0", i, bus1.report_valid);
      end
    end
    tick();
    checks++;
    if (bus1.report_valid !== 1'b1 || bus1.event_count !== 8'd2) begin
      errors++; $display("FAIL bp_second_report: got v=%0b e=%0d required 1 2",
                         bus1.report_valid, bus1.event_count);
    end
    bus1.block = 1'b0;
    tick();
  endtask

  task automatic test_accumulate();
    do_reset();
    bus1.report_ready = 1'b1;
    bus1.block = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      bus1.axis_block_sigs = (k == 3) ? 6'b000010 : (k == 15) ? 6'b010000 : 6'b000000;
      bus1.inst_idle_sigs = (k == 16) ? 4'h9 : 4'h1;
      tick();
    end
    checks++;
    if (bus1.report_valid !== 1'b1 || bus1.report_axis !== 6'b010010) begin
      errors++; $display("FAIL acc_or_window: got v=%0b ax=%b required 1 010010",
                         bus1.report_valid, bus1.report_axis);
    end
    checks++;
    if (bus1.report_idle !== 4'h9) begin
      errors++; $display("FAIL acc_idle_capture_cycle: got %0h required 9", bus1.report_idle);
    end
    bus1.block = 1'b0; bus1.axis_block_sigs = '0;
    repeat (2) tick();
    bus1.block = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      bus1.axis_block_sigs = (k == 16) ? 6'b100000 : 6'b000000;
      tick();
    end
    checks++;
    if (bus1.report_valid !== 1'b1 || bus1.report_axis !== 6'b100000) begin
      errors++; $display("FAIL acc_capture_cycle_bits: got v=%0b ax=%b required 1 100000",
                         bus1.report_valid, bus1.report_axis);
    end
    bus1.block = 1'b0;
    tick();
  endtask

  task automatic test_flag_priority();
    do_reset();
    bus1.report_ready = 1'b1;
    bus1.block = 1'b1;
    repeat (15) tick();
    bus1.flag_clear = 1'b1;
    tick();
    bus1.flag_clear = 1'b0;
    checks++;
    if (bus1.report_valid !== 1'b1 || bus1.deadlock_flag !== 1'b1) begin
      errors++; $display("FAIL flag_set_wins: got v=%0b f=%0b required 1 1",
                         bus1.report_valid, bus1.deadlock_flag);
    end
    tick();
    checks++;
    if (bus1.deadlock_flag !== 1'b1) begin
      errors++; $display("FAIL flag_sticky: got %0b required 1", bus1.deadlock_flag);
    end
    bus1.flag_clear = 1'b1;
    tick();
    bus1.flag_clear = 1'b0;
    checks++;
    if (bus1.deadlock_flag !== 1'b0) begin
      errors++; $display("FAIL flag_clear_later: got %0b required 0", bus1.deadlock_flag);
    end
    bus1.block = 1'b0;
    tick();
  endtask

  task automatic test_threshold1_saturation();
    int missing;
    do_reset();
    bus2.report_ready = 1'b1; bus2.axis_block_sigs = 6'h21; bus2.inst_idle_sigs = 4'h6;
    bus2.block = 1'b1;
    checks++;
    if (bus2.report_valid !== 1'b0) begin
      errors++; $display("FAIL thr1_not_same_cycle: got %0b required 0", bus2.report_valid);
    end
    tick();
    checks++;
    if (bus2.report_valid !== 1'b1 || bus2.report_ts !== 4'd0 || bus2.event_count !== 8'd1) begin
      errors++; $display("FAIL thr1_next_cycle: got v=%0b ts=%0d e=%0d required 1 0 1",
                         bus2.report_valid, bus2.report_ts, bus2.event_count);
    end
    checks++;
    if (bus2.report_axis !== 6'h21 || bus2.report_idle !== 4'h6) begin
      errors++; $display("FAIL thr1_data: got ax=%0h id=%0h required 21 6",
                         bus2.report_axis, bus2.report_idle);
    end
    bus2.block = 1'b0;
    repeat (2) tick();
    missing = 0;
    for (int i = 0; i < 254; i++) begin
      bus2.block = 1'b1;
      tick();
      if (bus2.report_valid !== 1'b1) missing++;
      bus2.block = 1'b0;
      repeat (2) tick();
    end
    checks++;
    if (missing !== 0) begin
      errors++; $display("FAIL sat_episodes_reported: got %0d missing required 0", missing);
    end
    checks++;
    if (bus2.event_count !== 8'd255) begin
      errors++; $display("FAIL sat_evt_255: got %0d required 255", bus2.event_count);
    end
    bus2.block = 1'b1;
    tick();
    checks++;
    if (bus2.report_valid !== 1'b1 || bus2.event_count !== 8'd255) begin
      errors++; $display("FAIL sat_evt_hold: got v=%0b e=%0d required 1 255",
                         bus2.report_valid, bus2.event_count);
    end
    checks++;
    if (bus2.report_ts !== 4'hF) begin
      errors++; $display("FAIL sat_ts_no_wrap: got %0d required 15", bus2.report_ts);
    end
    bus2.block = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_reset_midreport();
    test_nominal();
    test_glitch();
    test_backpressure();
    test_accumulate();
    test_flag_priority();
    test_threshold1_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
